// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample scheduler: sample width,
// scheduler state encoding and default pacing/buffer sizes.
package audio_pkg;

  // Width of one audio sample word.
  localparam int SAMPLE_W = 32;

  // Default clocks per sample period.
  localparam int DIV_DEFAULT = 16;

  // Default FIFO depth in samples (power of two, at least 2).
  localparam int DEPTH_DEFAULT = 4;

  // Scheduler states: IDLE (flushed, no requests), PRIME (filling the
  // FIFO before playback starts), RUN (paced playback).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous show-ahead FIFO for audio samples. The head entry is
// always visible on dout; pop only advances the read pointer. Flush empties
// the FIFO in one cycle and takes priority over push and pop. Pointers are
// log2(DEPTH) bits and wrap naturally, so DEPTH must be a power of two.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DATA_W = SAMPLE_W
) (
  input  logic                   c,
  input  logic                   r,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_EMPTY = LW'(0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     rd_ptr_d;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic              do_push;
  logic              do_pop;

  // Qualify push/pop: never write when full or read when empty, flush wins.
  always_comb begin
    do_push = push && !flush && (level_q != LVL_FULL);
    do_pop  = pop  && !flush && (level_q != LVL_EMPTY);
  end

  // Next pointer and occupancy values, including the simultaneous push/pop case.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      level_d  = LVL_EMPTY;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously on reset.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LVL_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers.
  always_ff @(posedge c) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/audio_sample_scheduler.sv
// Audio sample scheduler: buffers samples from a valid/ready source in a
// small FIFO and emits one sample with a one-cycle strobe every DIV clocks.
// Starvation at a sample tick raises a sticky underrun flag.
//
// Build option AUDIO_MUTE_ON_UNDERRUN_EN: when defined, an underrun tick
// forces the output sample to zero (still without a strobe); when undefined
// the output holds its last value.
module audio_sample_scheduler
  import audio_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   c,
  input  logic                   r,
  input  logic                   en,
  output logic                   req,
  input  logic                   ack,
  input  logic [SAMPLE_W-1:0]    din,
  output logic [SAMPLE_W-1:0]    x,
  output logic                   stb,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CNT_W = $clog2(DIV);
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [LW-1:0]    LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_LAST  = LW'(DEPTH - 1);
  localparam logic [LW-1:0]    LVL_EMPTY = LW'(0);

  sched_state_t        state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [SAMPLE_W-1:0] x_q;
  logic                stb_q;
  logic                underrun_q;

  logic [SAMPLE_W-1:0] fifo_dout;
  logic [LW-1:0]       fifo_level;
  logic                push;
  logic                pop;
  logic                flush;
  logic                tick;
  logic                prime_done;

  audio_sample_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (SAMPLE_W)
  ) u_fifo (
    .c     (c),
    .r     (r),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (fifo_dout),
    .level (fifo_level)
  );

  // Source handshake: ready whenever active and there is room.
  always_comb begin
    req  = (state_q != IDLE) && (fifo_level < LVL_FULL);
    push = req && ack;
  end

  // Tick/pop decode; a disable on the tick edge suppresses both.
  always_comb begin
    flush      = !en;
    tick       = en && (state_q == RUN) && (cnt_q == CNT_MAX);
    pop        = tick && (fifo_level != LVL_EMPTY);
    prime_done = (state_q == PRIME) && push && (fifo_level == LVL_LAST);
  end

  // Sample-period divider: runs only in RUN, wraps after DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (state_q == RUN)) begin
      if (tick) begin
        cnt_d = CNT_W'(0);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = CNT_W'(0);
    end
  end

  // Scheduler FSM with registered sample, strobe and underrun outputs.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_W'(0);
      x_q        <= {SAMPLE_W{1'b0}};
      stb_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            state_q    <= PRIME;
            underrun_q <= 1'b0;
          end
          PRIME: begin
            if (prime_done) begin
              state_q <= RUN;
            end
          end
          RUN: begin
            if (tick) begin
              if (fifo_level != LVL_EMPTY) begin
                x_q   <= fifo_dout;
                stb_q <= 1'b1;
              end else begin
                underrun_q <= 1'b1;
`ifdef AUDIO_MUTE_ON_UNDERRUN_EN
                x_q        <= {SAMPLE_W{1'b0}};
`endif
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign x        = x_q;
  assign stb      = stb_q;
  assign underrun = underrun_q;
  assign level    = fifo_level;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed bench for audio_sample_scheduler (DIV=16, DEPTH=4): a table of
// {inputs, cycles, expected outputs} records covering prime, paced output,
// simultaneous push/pop, underrun, disable and re-prime, followed by
// hand-written async-reset and back-pressure sequences.
module tb_audio_sample_scheduler;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  localparam int NVEC  = 28;

`ifdef AUDIO_MUTE_ON_UNDERRUN_EN
  localparam logic [31:0] HOLD_A = 32'd0;
  localparam logic [31:0] HOLD_B = 32'd0;
`else
  localparam logic [31:0] HOLD_A = 32'd7;
  localparam logic [31:0] HOLD_B = 32'd13;
`endif

  logic        c;
  logic        r;
  logic        en;
  logic        req;
  logic        ack;
  logic [31:0] din;
  logic [31:0] x;
  logic        stb;
  logic        underrun;
  logic [2:0]  level;

  int          total;
  int          passed;
  logic [31:0] next_val;

  typedef struct {
    logic        en;
    logic        ack;
    int          ncyc;
    logic        req;
    logic        stb;
    logic [31:0] x;
    logic [2:0]  lvl;
    logic        und;
  } vec_t;

  vec_t vecs [NVEC];

  audio_sample_scheduler #(
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .c        (c),
    .r        (r),
    .en       (en),
    .req      (req),
    .ack      (ack),
    .din      (din),
    .x        (x),
    .stb      (stb),
    .underrun (underrun),
    .level    (level)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // One clock: source presents next_val; it advances after an accepted transfer.
  task automatic cycle();
    logic moved;
    moved = req && ack;
    @(posedge c);
    @(negedge c);
    if (moved) begin
      next_val = next_val + 32'd1;
      din      = next_val;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic        found;
    int          delivered;
    int          pushed;
    logic [31:0] sb [$];

    total    = 0;
    passed   = 0;
    next_val = 32'd1;
    din      = 32'd1;
    r        = 1'b1;
    en       = 1'b0;
    ack      = 1'b0;

    //            en    ack   n   req   stb   x       lvl   und
    vecs[0]  = '{1'b0, 1'b0, 0,  1'b0, 1'b0, 32'd0,  3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1,  1'b1, 1'b0, 32'd0,  3'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1,  1'b1, 1'b0, 32'd0,  3'd1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 3,  1'b0, 1'b0, 32'd0,  3'd4, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 15, 1'b0, 1'b0, 32'd0,  3'd4, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 32'd1,  3'd3, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 32'd1,  3'd4, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 15, 1'b1, 1'b1, 32'd2,  3'd3, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 32'd2,  3'd4, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 15, 1'b1, 1'b1, 32'd3,  3'd3, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 15, 1'b1, 1'b0, 32'd3,  3'd3, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 32'd4,  3'd3, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 16, 1'b1, 1'b1, 32'd5,  3'd2, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 16, 1'b1, 1'b1, 32'd6,  3'd1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 16, 1'b1, 1'b1, 32'd7,  3'd0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 16, 1'b1, 1'b0, HOLD_A, 3'd0, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 2,  1'b1, 1'b0, HOLD_A, 3'd2, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 13, 1'b1, 1'b0, HOLD_A, 3'd2, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1,  1'b0, 1'b0, HOLD_A, 3'd0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 3,  1'b0, 1'b0, HOLD_A, 3'd0, 1'b1};
    vecs[20] = '{1'b1, 1'b0, 1,  1'b1, 1'b0, HOLD_A, 3'd0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 4,  1'b0, 1'b0, HOLD_A, 3'd4, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 15, 1'b0, 1'b0, HOLD_A, 3'd4, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 32'd10, 3'd3, 1'b0};
    vecs[24] = '{1'b1, 1'b0, 16, 1'b1, 1'b1, 32'd11, 3'd2, 1'b0};
    vecs[25] = '{1'b1, 1'b0, 16, 1'b1, 1'b1, 32'd12, 3'd1, 1'b0};
    vecs[26] = '{1'b1, 1'b0, 16, 1'b1, 1'b1, 32'd13, 3'd0, 1'b0};
    vecs[27] = '{1'b1, 1'b0, 16, 1'b1, 1'b0, HOLD_B, 3'd0, 1'b1};

    repeat (2) @(negedge c);
    r = 1'b0;

    // Table-driven section: apply inputs, run n clocks, compare outputs.
    for (int i = 0; i < NVEC; i++) begin
      en  = vecs[i].en;
      ack = vecs[i].ack;
      repeat (vecs[i].ncyc) cycle();
      check($sformatf("v%0d.req", i),   {31'd0, req},      {31'd0, vecs[i].req});
      check($sformatf("v%0d.stb", i),   {31'd0, stb},      {31'd0, vecs[i].stb});
      check($sformatf("v%0d.x", i),     x,                 vecs[i].x);
      check($sformatf("v%0d.level", i), {29'd0, level},    {29'd0, vecs[i].lvl});
      check($sformatf("v%0d.underrun", i), {31'd0, underrun}, {31'd0, vecs[i].und});
    end

    // Async reset mid-RUN: wait for a strobe, then reset between edges.
    ack   = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (stb) begin
        found = 1'b1;
      end
    end
    check("rst.stb_seen", {31'd0, found}, 32'd1);
    check("rst.x_before", x, 32'd14);
    #2;
    r = 1'b1;
    #1;
    check("rst.x",        x,                 32'd0);
    check("rst.stb",      {31'd0, stb},      32'd0);
    check("rst.level",    {29'd0, level},    32'd0);
    check("rst.underrun", {31'd0, underrun}, 32'd0);
    check("rst.req",      {31'd0, req},      32'd0);
    @(negedge c);
    ack = 1'b0;
    r   = 1'b0;
    check("rst.idle_req", {31'd0, req}, 32'd0);
    cycle();
    check("rst.prime_req",   {31'd0, req},   32'd1);
    check("rst.prime_level", {29'd0, level}, 32'd0);

    // Back-pressure: source offers a sample only every 20 clocks.
    delivered = 0;
    pushed    = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      ack = ((cyc % 20) == 0);
      if (req && ack) begin
        sb.push_back(din);
        pushed = pushed + 1;
      end
      cycle();
      if (stb) begin
        check("bp.queue_has_sample", {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
          check($sformatf("bp.order%0d", delivered), x, sb[0]);
          void'(sb.pop_front());
          delivered = delivered + 1;
        end
      end
    end
    ack = 1'b0;
    check("bp.underrun", {31'd0, underrun}, 32'd1);
    check("bp.level_balance", {29'd0, level}, 32'(pushed - delivered));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/audio_sample_scheduler.md
# audio_sample_scheduler

Paces 32-bit audio samples from a sample source (simulation fetch model or upstream decoder) into the audio output at a fixed sample period. It buffers samples in a small FIFO, requests new samples from the source over a valid/ready handshake, and emits one sample plus a one-cycle strobe every `DIV` clocks. Underruns are flagged sticky so the bench or host can detect starved playback.

## Interface
- `DIV`, 16: clock cycles per sample period; legal range ≥ 2.
- `DEPTH`, 4: FIFO depth in samples; must be a power of two, ≥ 2.
- `c`  input  1: clock, rising edge. One clock; reset is asynchronous and active-high.
- `r`  input  1: reset; asynchronous, active-high.
- `en`  input  1: playback enable, level-sensitive.
- `req`  output  1: ready to accept a sample. Combinational: `(state != IDLE) && (level < DEPTH)`.
- `ack`  input  1: source has valid data on `din`. A transfer occurs on a rising edge where `req && ack`.
- `din`  input  32: sample from source.
- `x`  output  32: current output sample, registered.
- `stb`  output  1: one-cycle pulse when `x` takes a new value at a sample tick.
- `underrun`  output  1: sticky starvation flag.
- `level`  output  $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- States:
  - IDLE: FIFO empty, divider held at 0, `req` = 0.
  - PRIME: accept samples until the FIFO is full.
  - RUN: accept samples whenever not full; pop one sample per tick.
- Transitions:
  - IDLE→PRIME when `en` = 1. Entry clears `underrun`.
  - PRIME→RUN on the edge where `level` becomes `DEPTH`.
  - Any state→IDLE when `en` = 0. FIFO is flushed, `level` = 0, and `x` holds its last value.
- Divider: `cnt` counts 0..`DIV`-1 in RUN only, wrapping to 0. A tick occurs at the edge where `cnt` == `DIV`-1.
- Tick with FIFO non-empty: at that edge `x` ← FIFO head, `stb` ← 1, and the head is popped.
- Tick with FIFO empty: `underrun` ← 1 and `stb` ← 0; `x` behaves per Configuration. The state stays RUN.
- Simultaneous push and pop in one cycle: `level` is unchanged and data order is preserved.
- Push when full cannot occur because `req` is low. Pop when empty is not performed.
- `level` arithmetic is unsigned and never exceeds `DEPTH`. FIFO read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.

## Timing
- Reset values: `x` = 0, `stb` = 0, `underrun` = 0, `level` = 0, state IDLE, `cnt` = 0. `req` = 0 as a consequence.
- Reset asserted mid-playback forces these values immediately, without waiting for a clock edge.
- `req` responds to a `level` change in the same cycle (combinational from registers).
- First `stb` occurs exactly `DIV` cycles after the PRIME→RUN edge. Subsequent `stb` pulses are spaced exactly `DIV` cycles apart while samples are available.
- Latency from a sample being accepted to it appearing on `x` is data-dependent. The minimum is 1 cycle, in the case where the FIFO was empty and the next tick occurs on the following edge.
- `en` falling on a tick edge: the IDLE transition wins, so there is no `stb` and no pop.

## Configuration
- `AUDIO_MUTE_ON_UNDERRUN_EN`
  - Defined: an underrun tick loads `x` ← 0 but keeps `stb` = 0.
  - Undefined: an underrun tick holds `x` at its last value.
- `underrun` flag behaviour is identical in both builds.

## Structure
- Shared package `audio_pkg` holds:
  - `SAMPLE_W` = 32;
  - the state enum `sched_state_t` {IDLE, PRIME, RUN};
  - the default constants for `DIV` and `DEPTH`.
- Sub-module `audio_sample_fifo`:
  - synchronous FIFO parameterised by `DEPTH` and `SAMPLE_W`;
  - ports: push, pop, flush, din, dout (head, show-ahead), level;
  - same clock `c` and async reset `r`.
- The scheduler contains the FSM, the divider and the output registers.

## Test plan
- Reset and prime: `DIV`=16, `DEPTH`=4, source always acks samples 1,2,3,4…
  - Required: `req` falls after 4 transfers.
  - Required: first `stb` occurs 16 cycles after entering RUN, with `x` = 1.
  - Required: next `stb` pulses show `x` = 2, 3 at 16-cycle spacing.
- Underrun: after priming, the source stops acking.
  - Required: 4 `stb` pulses, then `underrun` = 1 on the 5th tick with no `stb`.
  - Required: `x` = 4 when `AUDIO_MUTE_ON_UNDERRUN_EN` is undefined, `x` = 0 when it is defined.
- Simultaneous push/pop: level = 3 in RUN, ack asserted on the tick edge.
  - Required: `level` stays 3 and the output order is preserved.
- Disable mid-playback: drop `en` on a tick edge with level 2.
  - Required: no `stb`, `level` = 0, `x` unchanged, `req` = 0 next cycle.
  - Required: re-enabling clears `underrun` and re-primes.
- Async reset mid-RUN: assert `r` between edges.
  - Required: `x`, `stb`, `level` and `underrun` go to 0 immediately; state returns to IDLE.
- Back-pressure: source acks only every 20 cycles with `DIV`=16.
  - Required: `underrun` is eventually set, and every delivered sample appears exactly once, in order.
